// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit.
// Multiplies use shift-add and divides use restoring division on operand
// magnitudes, one bit per cycle; signs are corrected in a separate FIX cycle.
// Divide-by-zero and signed overflow finish without iterating.
// Optional macro MULDIV_FAST_MUL_EN: multiplies complete in a single cycle
// through a combinational multiplier; divides are unaffected.
// The reset port is named 'reset' and is asynchronous, active low.

module muldiv_unit #(
    parameter int DATA_W     = 32,
    parameter int RF_ADDRESS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            funct3,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    input  logic [RF_ADDRESS-1:0] rd_in,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     result,
    output logic [RF_ADDRESS-1:0] rd_out,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(DATA_W);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                state, state_nx;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_W-1:0]     hi, lo, divisor;
    logic [2:0]            op_q;
    logic                  neg_q;

    logic                  accept, is_div, a_signed, b_signed, a_neg, b_neg;
    logic                  div_zero, div_ovf, fast_take;
    logic [DATA_W-1:0]     mag_a, mag_b, fast_result, fix_result;
    logic [DATA_W:0]       mul_sum, div_shift, div_diff;
    logic                  div_ok;
    logic [2*DATA_W-1:0]   prod_fix;

    // Operand decode: which operands are signed, their magnitudes and the
    // special divide cases that bypass the iteration.
    assign is_div   = funct3[2];
    assign a_signed = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                      (funct3 == F_DIV)  || (funct3 == F_REM);
    assign b_signed = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
    assign a_neg    = a_signed && op_a[DATA_W-1];
    assign b_neg    = b_signed && op_b[DATA_W-1];
    assign mag_a    = a_neg ? -op_a : op_a;
    assign mag_b    = b_neg ? -op_b : op_b;
    assign div_zero = is_div && (op_b == '0);
    assign div_ovf  = is_div && !funct3[0] && (op_a == MOST_NEG) && (op_b == '1);
    assign accept   = in_valid && in_ready && !flush;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*DATA_W-1:0] ext_a, ext_b, fast_prod;

    // Sign-extended operands give the correct 2*DATA_W product bits even
    // with an unsigned multiplier.
    assign ext_a     = {{DATA_W{a_neg}}, op_a};
    assign ext_b     = {{DATA_W{b_neg}}, op_b};
    assign fast_prod = ext_a * ext_b;
    assign fast_take = div_zero || div_ovf || !is_div;

    // Single-cycle results: multiplies plus the special divide cases.
    always_comb begin
        fast_result = '0;
        if (!is_div)
            fast_result = (funct3 == F_MUL) ? fast_prod[DATA_W-1:0]
                                            : fast_prod[2*DATA_W-1:DATA_W];
        else if (div_zero)
            fast_result = funct3[1] ? op_a : '1;
        else
            fast_result = funct3[1] ? '0 : op_a;
    end
`else
    assign fast_take = div_zero || div_ovf;

    // Single-cycle results for divide-by-zero and signed overflow.
    always_comb begin
        fast_result = '0;
        if (div_zero)
            fast_result = funct3[1] ? op_a : '1;
        else
            fast_result = funct3[1] ? '0 : op_a;
    end
`endif

    // One iteration step: hi/lo hold the partial product, or the partial
    // remainder and the quotient shifting in from the right.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, divisor} : '0);
        div_shift = {hi, lo[DATA_W-1]};
        div_diff  = div_shift - {1'b0, divisor};
        div_ok    = !div_diff[DATA_W];
    end

    // Sign correction and result selection applied in the FIX cycle.
    always_comb begin
        prod_fix   = neg_q ? -{hi, lo} : {hi, lo};
        fix_result = '0;
        if (!op_q[2])
            fix_result = (op_q == F_MUL) ? prod_fix[DATA_W-1:0]
                                         : prod_fix[2*DATA_W-1:DATA_W];
        else if (!op_q[1])
            fix_result = neg_q ? -lo : lo;
        else
            fix_result = neg_q ? -hi : hi;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state and handshake outputs; flush wins over everything else.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (accept)
                    state_nx = fast_take ? DONE : CALC;
            end
            CALC: begin
                if (flush)
                    state_nx = IDLE;
                else if (cnt == LAST_ITER)
                    state_nx = FIX;
            end
            FIX: begin
                state_nx = flush ? IDLE : DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (flush || out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, iterate in CALC, and hold the
    // result/tag stable from FIX until the next accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            divisor <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= funct3;
                        rd_out  <= rd_in;
                        hi      <= '0;
                        lo      <= mag_a;
                        divisor <= mag_b;
                        cnt     <= '0;
                        neg_q   <= (funct3 == F_REM) ? a_neg : (a_neg ^ b_neg);
                        if (fast_take)
                            result <= fast_result;
                    end
                end
                CALC: begin
                    cnt <= (cnt == MAX_CNT) ? cnt : cnt + 1'b1;
                    if (op_q[2]) begin
                        hi <= div_ok ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
                        lo <= {lo[DATA_W-2:0], div_ok};
                    end else begin
                        hi <= mul_sum[DATA_W:1];
                        lo <= {mul_sum[0], lo[DATA_W-1:1]};
                    end
                end
                FIX: begin
                    result <= fix_result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
